// File: rtl/buffer_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : buffer_writer_pkg                                          |
// | Purpose  : Shared state type and default sizes for buffer_writer.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package buffer_writer_pkg;

    // FILL: accepting samples into the RAM; DONE: frame frozen awaiting release.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        DONE = 1'b1
    } bw_state_t;

    localparam int BW_DEPTH  = 32;
    localparam int BW_ADDR_W = 5;
    localparam int BW_DATA_W = 24;
    localparam int BW_FCNT_W = 8;

endpackage : buffer_writer_pkg
`default_nettype wire

// File: rtl/wrap_addr_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wrap_addr_counter                                          |
// | Purpose  : ADDR_W-bit write pointer with increment enable, async      |
// |            active-low clear and a terminal-count flag at DEPTH-1.     |
// |            DEPTH is a power of two, so the natural binary rollover    |
// |            provides the wrap to zero.                                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module wrap_addr_counter #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_tc
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_count;

    // Pointer register: advance by one per enabled cycle, rolling over at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + ADDR_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == c_last);

endmodule : wrap_addr_counter
`default_nettype wire

// File: rtl/buffer_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : buffer_writer                                              |
// | Purpose  : Fills a DEPTH-entry sample RAM from a valid/ready stream,  |
// |            raises write_done after the last word and holds the frame  |
// |            until the downstream wait stage returns waited.            |
// | Options  : BUFFER_WRITER_OVERFLOW_EN - build the sticky overflow flag |
// |            for samples offered while the frame is frozen.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module buffer_writer
    import buffer_writer_pkg::*;
#(
    parameter int DEPTH  = BW_DEPTH,
    parameter int ADDR_W = BW_ADDR_W,
    parameter int DATA_W = BW_DATA_W,
    parameter int FCNT_W = BW_FCNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              waited,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              write_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              overflow
);

    bw_state_t         r_state;
    bw_state_t         w_state_next;
    logic              w_accept;
    logic              w_last;
    logic [ADDR_W-1:0] w_ptr;
    logic              w_ptr_tc;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [FCNT_W-1:0] r_frame_cnt;

    assign in_ready = (r_state == FILL);
    assign w_accept = in_valid & in_ready;
    assign w_last   = w_accept & w_ptr_tc;

    wrap_addr_counter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_accept),
        .o_count (w_ptr),
        .o_tc    (w_ptr_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: freeze after the final word, rearm on waited seen in DONE only.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_last) w_state_next = DONE;
            DONE:    if (waited) w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    // Write port: one registered strobe per accepted word; address/data hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= w_ptr;
                r_wr_data <= in_data;
            end
        end
    end

    // Completed-frame counter, bumped alongside the final write; wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= '0;
        end else if (w_last) begin
            r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
        end
    end

`ifdef BUFFER_WRITER_OVERFLOW_EN
    logic r_overflow;

    // Sticky flag for any sample offered while the frame is frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if ((r_state == DONE) && in_valid) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    // Decoded straight from the state flop, so no input reaches it combinationally.
    assign write_done = (r_state == DONE);
    assign frame_cnt  = r_frame_cnt;

endmodule : buffer_writer
`default_nettype wire
